// File: rtl/bist_pkg.sv
// Shared types and constants for the memory BIST pattern sequencer.
package bist_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRIME,
    S_WR,
    S_RD,
    S_CMP,
    S_ADV,
    S_DONE
  } bist_state_e;

  localparam logic [15:0] LFSR_SEED        = 16'h8000;
  // PRIME plus one WR/RD/CMP/ADV slot before the first step, then one step per slot
  localparam int          LFSR_FIRST_STEP  = 5;
  localparam int          LFSR_STEP_PERIOD = 4;

  localparam int PAT_W  = 16;
  localparam int FCNT_W = 4;

  function automatic logic [FCNT_W-1:0] sat_inc(input logic [FCNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

endpackage

// File: rtl/bist_fail_log.sv
// Fail accounting for the BIST sweep: registered fail pulse/address,
// saturating fail counter and sticky overflow flag.
module bist_fail_log
  import bist_pkg::*;
#(
  parameter int AW       = 6,
  parameter int MAX_FAIL = 4
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              clr,
  input  logic              cmp_vld,
  input  logic              mismatch,
  input  logic [AW-1:0]     addr,
  output logic              fail_vld,
  output logic [AW-1:0]     fail_addr,
  output logic [FCNT_W-1:0] fail_cnt,
  output logic              overflow
);

  localparam logic [FCNT_W-1:0] MAX_FAIL_C = FCNT_W'(MAX_FAIL);

  logic              hit;
  logic [FCNT_W-1:0] cnt_nxt;

  assign hit     = cmp_vld & mismatch;
  assign cnt_nxt = sat_inc(fail_cnt);

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      fail_vld  <= 1'b0;
      fail_addr <= '0;
      fail_cnt  <= '0;
      overflow  <= 1'b0;
    end else if (clr) begin
      fail_vld  <= 1'b0;
      fail_addr <= '0;
      fail_cnt  <= '0;
      overflow  <= 1'b0;
    end else begin
      fail_vld <= hit;
      // count lands together with the pulse, so OVERFLOW rises on the pulse that crosses MAX_FAIL
      if (hit) begin
        fail_addr <= addr;
        fail_cnt  <= cnt_nxt;
        if (cnt_nxt > MAX_FAIL_C) overflow <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/bist_pattern_seq.sv
// Memory BIST sequencer: write/read-back/compare sweep driven by the pattern LFSR.
// Define BIST_INV_PASS_EN to add a second sweep writing and comparing ~PAT.
module bist_pattern_seq
  import bist_pkg::*;
#(
  parameter int AW       = 6,
  parameter int MAX_FAIL = 4
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic              LFSR_EN,
  input  logic [PAT_W-1:0]  PAT,
  output logic              MEM_CS,
  output logic              MEM_WE,
  output logic [AW-1:0]     MEM_ADDR,
  output logic [PAT_W-1:0]  MEM_WDATA,
  input  logic [PAT_W-1:0]  MEM_RDATA,
  output logic              FAIL_VLD,
  output logic [AW-1:0]     FAIL_ADDR,
  output logic [FCNT_W-1:0] FAIL_CNT,
  output logic              OVERFLOW
);

  bist_state_e      state_q, state_d;
  logic [AW-1:0]    addr_q;
  logic             accept;
  logic             last_addr;
  logic             sweep_end;
  logic [PAT_W-1:0] wdata;

  assign accept    = (state_q == S_IDLE) & START;
  assign last_addr = &addr_q;

`ifdef BIST_INV_PASS_EN
  logic pass_q;
  assign wdata     = pass_q ? ~PAT : PAT;
  assign sweep_end = last_addr & pass_q;
`else
  assign wdata     = PAT;
  assign sweep_end = last_addr;
`endif

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    BUSY      = 1'b1;
    DONE      = 1'b0;
    LFSR_EN   = 1'b1;
    MEM_CS    = 1'b0;
    MEM_WE    = 1'b0;
    MEM_WDATA = '0;
    unique case (state_q)
      S_IDLE: begin
        BUSY    = 1'b0;
        LFSR_EN = 1'b0;
        if (START) state_d = S_PRIME;
      end
      S_PRIME: state_d = S_WR;
      S_WR: begin
        MEM_CS    = 1'b1;
        MEM_WE    = 1'b1;
        MEM_WDATA = wdata;
        state_d   = S_RD;
      end
      S_RD: begin
        MEM_CS  = 1'b1;
        state_d = S_CMP;
      end
      S_CMP: state_d = S_ADV;
      // LFSR_EN stays high here across the pass boundary so the LFSR keeps its cadence
      S_ADV: state_d = sweep_end ? S_DONE : S_WR;
      S_DONE: begin
        DONE    = 1'b1;
        LFSR_EN = 1'b0;
        state_d = S_IDLE;
      end
      default: begin
        BUSY    = 1'b0;
        LFSR_EN = 1'b0;
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      addr_q <= '0;
`ifdef BIST_INV_PASS_EN
      pass_q <= 1'b0;
`endif
    end else if (accept) begin
      addr_q <= '0;
`ifdef BIST_INV_PASS_EN
      pass_q <= 1'b0;
`endif
    end else if (state_q == S_ADV) begin
      addr_q <= addr_q + 1'b1;
`ifdef BIST_INV_PASS_EN
      if (last_addr) pass_q <= ~pass_q;
`endif
    end
  end

  assign MEM_ADDR = addr_q;

  bist_fail_log #(
    .AW       (AW),
    .MAX_FAIL (MAX_FAIL)
  ) u_fail_log (
    .CLK       (CLK),
    .RSTN      (RSTN),
    .clr       (accept),
    .cmp_vld   (state_q == S_CMP),
    .mismatch  (MEM_RDATA != wdata),
    .addr      (addr_q),
    .fail_vld  (FAIL_VLD),
    .fail_addr (FAIL_ADDR),
    .fail_cnt  (FAIL_CNT),
    .overflow  (OVERFLOW)
  );

endmodule

// File: tb/tb_bist_pattern_seq.sv
// Bench for bist_pattern_seq: LFSR + faulty memory environment, cycle-level
// reference model from run position arithmetic, directed and random runs.
`timescale 1ns/1ps
module tb_bist_pattern_seq;
  import bist_pkg::*;

  localparam int AW       = 3;
  localparam int N        = 1 << AW;
  localparam int MAX_FAIL = 4;
`ifdef BIST_INV_PASS_EN
  localparam int P        = 2;
  localparam int DONE_LIT = 66;
  localparam int T2_CNT   = 2;
  localparam int T3_CNT   = 15;
`else
  localparam int P        = 1;
  localparam int DONE_LIT = 34;
  localparam int T2_CNT   = 1;
  localparam int T3_CNT   = 8;
`endif
  localparam int RUN_LEN  = 2 + 4 * N * P;

  logic          CLK = 1'b0, RSTN = 1'b1, START = 1'b0;
  logic          BUSY, DONE, LFSR_EN, MEM_CS, MEM_WE, FAIL_VLD, OVERFLOW;
  logic [15:0]   PAT, MEM_WDATA, MEM_RDATA;
  logic [AW-1:0] MEM_ADDR, FAIL_ADDR;
  logic [3:0]    FAIL_CNT;
  int checks = 0, errors = 0;

  always #5 CLK = ~CLK;

  bist_pattern_seq #(.AW(AW), .MAX_FAIL(MAX_FAIL)) dut (
    .CLK(CLK), .RSTN(RSTN), .START(START), .BUSY(BUSY), .DONE(DONE),
    .LFSR_EN(LFSR_EN), .PAT(PAT), .MEM_CS(MEM_CS), .MEM_WE(MEM_WE),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_RDATA(MEM_RDATA),
    .FAIL_VLD(FAIL_VLD), .FAIL_ADDR(FAIL_ADDR), .FAIL_CNT(FAIL_CNT),
    .OVERFLOW(OVERFLOW)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // pattern LFSR: holds for the first 5 enabled cycles, then steps every 4
  logic [15:0] lfsr;
  int en_cnt;
  function automatic logic [15:0] lfsr_next(input logic [15:0] v);
    return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
  endfunction
  always @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      lfsr <= LFSR_SEED; en_cnt <= 0;
    end else if (!LFSR_EN) en_cnt <= 0;
    else begin
      en_cnt <= en_cnt + 1;
      if (en_cnt + 1 >= LFSR_FIRST_STEP && (en_cnt + 1 - LFSR_FIRST_STEP) % LFSR_STEP_PERIOD == 0)
        lfsr <= lfsr_next(lfsr);
    end
  assign PAT = lfsr;

  // memory with per-address stuck-at masks, 1-cycle read latency
  logic [15:0] mem [N];
  logic [15:0] sa0 [N];
  logic [15:0] sa1 [N];
  function automatic logic [15:0] faulty(input logic [15:0] v, input int a);
    return (v & ~sa0[a]) | sa1[a];
  endfunction
  always @(posedge CLK) begin
    if (MEM_CS && MEM_WE)  mem[MEM_ADDR] <= MEM_WDATA;
    if (MEM_CS && !MEM_WE) MEM_RDATA <= faulty(mem[MEM_ADDR], int'(MEM_ADDR));
  end

  // reference model: k = cycle index within the run (-1 idle, 1 PRIME, slots, RUN_LEN = DONE)
  int k = -1, m_cnt = 0;
  logic [15:0] slot_w;
  function automatic int sat15(input int v);
    return (v > 15) ? 15 : v;
  endfunction
  function automatic bit in_slot(input int kk);
    return kk >= 2 && kk <= 1 + 4 * N * P;
  endfunction
  function automatic logic [15:0] exp_w(input int kk, input logic [15:0] pat);
    logic [15:0] r;
    r = (((kk - 2) / 4) / N != 0) ? ~pat : pat;
    return r;
  endfunction

  always @(posedge CLK or negedge RSTN)
    if (!RSTN) begin
      k <= -1; m_cnt <= 0;
    end else begin
      if (k < 0) begin
        if (START) begin k <= 1; m_cnt <= 0; end
      end else if (k == RUN_LEN) k <= -1;
      else k <= k + 1;
      if (in_slot(k) && (k - 2) % 4 == 0) slot_w <= exp_w(k, lfsr);
      if (in_slot(k) && (k - 2) % 4 == 3)
        m_cnt <= sat15(m_cnt + int'(faulty(slot_w, ((k - 2) / 4) % N) != slot_w));
    end

  always @(negedge CLK) begin : cmp
    int s, ph, a, c;
    bit ins, f;
    logic [15:0] ew;
    ins = in_slot(k);
    s   = ins ? (k - 2) / 4 : 0;
    ph  = ins ? (k - 2) % 4 : 0;
    a   = s % N;
    f   = ins && ph == 3 && (faulty(slot_w, a) != slot_w);
    c   = (ins && ph == 3) ? sat15(m_cnt + int'(f)) : m_cnt;
    ew  = (ins && ph == 0) ? exp_w(k, lfsr) : 16'h0;
    chk("busy",      BUSY,      k >= 1);
    chk("done",      DONE,      k == RUN_LEN);
    chk("lfsr_en",   LFSR_EN,   k >= 1 && k < RUN_LEN);
    chk("mem_cs",    MEM_CS,    ins && ph < 2);
    chk("mem_we",    MEM_WE,    ins && ph == 0);
    chk("mem_addr",  MEM_ADDR,  ins ? a : 0);
    chk("mem_wdata", MEM_WDATA, ew);
    chk("fail_vld",  FAIL_VLD,  f);
    if (f) chk("fail_addr", FAIL_ADDR, a);
    chk("fail_cnt",  FAIL_CNT,  c);
    chk("overflow",  OVERFLOW,  c > MAX_FAIL);
  end

  // observation logs for directed checks
  logic [AW-1:0] wlog_a[$], flog[$];
  logic [15:0]   wlog_d[$];
  int            fk[$];
  logic          ovlog[$];
  always @(negedge CLK) begin
    if (MEM_CS && MEM_WE) begin wlog_a.push_back(MEM_ADDR); wlog_d.push_back(MEM_WDATA); end
    if (FAIL_VLD) begin flog.push_back(FAIL_ADDR); fk.push_back(k); ovlog.push_back(OVERFLOW); end
  end

  task automatic clear_logs();
    wlog_a.delete(); wlog_d.delete(); flog.delete(); fk.delete(); ovlog.delete();
  endtask

  task automatic clear_faults();
    for (int i = 0; i < N; i++) begin sa0[i] = '0; sa1[i] = '0; end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_busy"},  BUSY, 0);      chk({tag, "_done"},  DONE, 0);
    chk({tag, "_lfsr"},  LFSR_EN, 0);   chk({tag, "_cs"},    MEM_CS, 0);
    chk({tag, "_we"},    MEM_WE, 0);    chk({tag, "_addr"},  MEM_ADDR, 0);
    chk({tag, "_wdata"}, MEM_WDATA, 0); chk({tag, "_fvld"},  FAIL_VLD, 0);
    chk({tag, "_faddr"}, FAIL_ADDR, 0); chk({tag, "_fcnt"},  FAIL_CNT, 0);
    chk({tag, "_ovf"},   OVERFLOW, 0);
  endtask

  task automatic reset_pulse();
    @(negedge CLK); RSTN = 1'b0;
    @(negedge CLK); RSTN = 1'b1;
  endtask

  // lat = cycles from the START sample to DONE; p_cnt/p_ov sampled in PRIME
  task automatic do_run(input int glitch_k, output int lat, output logic [3:0] p_cnt, output logic p_ov);
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    lat = 1; p_cnt = FAIL_CNT; p_ov = OVERFLOW;
    while (DONE !== 1'b1 && lat < RUN_LEN + 20) begin
      @(negedge CLK);
      lat++;
      START = (lat == glitch_k);
    end
    START = 1'b0;
    chk("run_timeout", DONE, 1'b1);
  endtask

  initial begin : wdog
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    int lat;
    logic [3:0] pc;
    logic pov;
    logic [15:0] held;
    clear_faults();
    #1 RSTN = 1'b0;
    #1 chk_reset("rst");
    repeat (3) @(negedge CLK);
    RSTN = 1'b1;

    // fault-free sweep from the seed
    clear_logs();
    do_run(0, lat, pc, pov);
    chk("t1_lat", lat, DONE_LIT);
    chk("t1_nwr", wlog_d.size(), N * P);
    chk("t1_w0", wlog_d[0], 16'h8000); chk("t1_a0", wlog_a[0], 0);
    chk("t1_w1", wlog_d[1], 16'h0001); chk("t1_a1", wlog_a[1], 1);
    chk("t1_w2", wlog_d[2], 16'h0002); chk("t1_a2", wlog_a[2], 2);
    chk("t1_w3", wlog_d[3], 16'h0004); chk("t1_a3", wlog_a[3], 3);
`ifdef BIST_INV_PASS_EN
    chk("t1_p1w0", wlog_d[N], 16'hFF7F);     chk("t1_p1a0", wlog_a[N], 0);
    chk("t1_p1w3", wlog_d[N + 3], 16'hFBFF); chk("t1_p1a3", wlog_a[N + 3], 3);
`endif
    chk("t1_nofail", flog.size(), 0);

    // stuck-at-0 on bit 0 of address 1
    reset_pulse();
    sa0[1] = 16'h0001;
    clear_logs();
    do_run(0, lat, pc, pov);
    chk("t2_nfail", flog.size(), T2_CNT);
    chk("t2_faddr", flog[0], 1);
    chk("t2_fk", fk[0], 9);
    chk("t2_cnt", FAIL_CNT, T2_CNT);
    chk("t2_ovf", OVERFLOW, 0);
    clear_faults();

    // every address faulty -> overflow on the 5th fail
    for (int i = 0; i < N; i++) sa0[i] = 16'hFFFF;
    clear_logs();
    do_run(0, lat, pc, pov);
    chk("t3_nfail", flog.size(), N * P);
    chk("t3_ov4", ovlog[3], 0);
    chk("t3_ov5", ovlog[4], 1);
    chk("t3_cnt", FAIL_CNT, T3_CNT);
    chk("t3_ovf", OVERFLOW, 1);
    clear_faults();

    // back-to-back run, START glitch while busy, fail state cleared by START
    held = lfsr;
    clear_logs();
    do_run(20, lat, pc, pov);
    chk("t4_clr_cnt", pc, 0);
    chk("t4_clr_ovf", pov, 0);
    chk("t4_lat", lat, DONE_LIT);
    chk("t4_w0", wlog_d[0], held);
    chk("t4_nofail", flog.size(), 0);

    // asynchronous reset mid-run
    @(negedge CLK); START = 1'b1;
    @(negedge CLK); START = 1'b0;
    repeat ($urandom_range(30, 5)) @(negedge CLK);
    #2 RSTN = 1'b0;
    #1 chk_reset("abort");
    @(negedge CLK); RSTN = 1'b1;
    clear_logs();
    do_run(0, lat, pc, pov);
    chk("t5_w0", wlog_d[0], 16'h8000);
    chk("t5_lat", lat, DONE_LIT);

    // random fault maps, random gaps and glitches
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < N; i++) begin
        sa0[i] = '0; sa1[i] = '0;
        if ($urandom_range(3) == 0) begin
          if ($urandom_range(1) == 1) sa0[i] = 16'h0001 << $urandom_range(15);
          else                        sa1[i] = 16'h0001 << $urandom_range(15);
        end
      end
      repeat ($urandom_range(3)) @(negedge CLK);
      do_run($urandom_range(RUN_LEN - 1, 2), lat, pc, pov);
      chk("rnd_lat", lat, RUN_LEN);
      chk("rnd_clr", pc, 0);
    end
    clear_faults();

    repeat (3) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bist_pattern_seq.md
# bist_pattern_seq

Memory BIST sequencer that sits directly downstream of the 16-bit pattern LFSR in the memory controller's BISR path. It drives the LFSR enable, consumes the LFSR output as write data, and runs a write/read-back/compare sweep over every address of the repairable array. Mismatching addresses are reported one at a time to the BISR repair-register logic, together with a saturating fail count and an overflow (unrepairable) flag.

## Interface
- AW, 6, memory address width; the sweep covers 2^AW words.
- MAX_FAIL, 4, number of fails the repair logic can absorb; OVERFLOW sets above this.
- CLK  in  1  clock.
- RSTN  in  1  reset, asynchronous, active-low.
- START  in  1  one-cycle pulse that begins a run; ignored unless the FSM is in IDLE.
- BUSY  out  1  high in every state except IDLE.
- DONE  out  1  one-cycle pulse when the run ends.
- LFSR_EN  out  1  enable to the pattern LFSR.
- PAT  in  16  LFSR output word.
- MEM_CS  out  1  memory chip select.
- MEM_WE  out  1  memory write enable.
- MEM_ADDR  out  AW  memory address.
- MEM_WDATA  out  16  memory write data.
- MEM_RDATA  in  16  memory read data; 1-cycle read latency.
- FAIL_VLD  out  1  one-cycle pulse, one per mismatch.
- FAIL_ADDR  out  AW  failing address; valid while FAIL_VLD is high.
- FAIL_CNT  out  4  fails in the current run, saturating at 15.
- OVERFLOW  out  1  sticky: FAIL_CNT > MAX_FAIL.

## Operation
- States and transitions:
  - IDLE -> PRIME on START.
  - PRIME -> WR.
  - WR -> RD -> CMP -> ADV.
  - ADV -> WR while the sweep is not finished; ADV -> DONE on the last address of the last pass.
  - DONE -> IDLE.
- LFSR_EN is decoded from state: high in PRIME, WR, RD, CMP and ADV; low in IDLE and DONE.
- Alignment to the LFSR cadence:
  - The LFSR holds its word for the first 5 enabled cycles (PRIME plus the first slot) and then for every further 4 cycles.
  - This places exactly one new PAT word at the start of each WR.
- Memory strobes:
  - WR: MEM_CS=1, MEM_WE=1, MEM_WDATA = PAT (pass 0) or ~PAT (pass 1).
  - RD: MEM_CS=1, MEM_WE=0.
  - All other states: MEM_CS=0, MEM_WE=0.
  - MEM_ADDR comes from the address counter and is constant across a slot.
- Compare:
  - In CMP, MEM_RDATA is checked against the word written in the same slot; PAT is still stable at that point.
  - The mismatch result is registered, so FAIL_VLD/FAIL_ADDR assert in ADV.
- Address counter:
  - Increments in ADV and wraps 2^AW-1 -> 0.
  - Wrap ends pass 0 (goes to pass 1 when inverse passes are compiled in) or ends the run.
- Fail accounting:
  - FAIL_CNT increments per FAIL_VLD and saturates at 15.
  - OVERFLOW sets when FAIL_CNT exceeds MAX_FAIL and stays set until the next accepted START.
  - An address failing in both passes is reported twice; the BISR logic deduplicates.
- An accepted START clears FAIL_CNT, OVERFLOW, the address counter and the pass bit.
- START while BUSY has no effect.

## Timing
- Reset values: BUSY=0, DONE=0, LFSR_EN=0, MEM_CS=0, MEM_WE=0, MEM_ADDR=0, MEM_WDATA=0, FAIL_VLD=0, FAIL_ADDR=0, FAIL_CNT=0, OVERFLOW=0; state IDLE.
- START sampled in cycle t -> PRIME in cycle t+1 -> first WR in cycle t+2.
- One pass takes 4·2^AW cycles. The run takes 1 + 4·2^AW·P + 1 cycles including DONE, where P is the pass count.
- LFSR_EN stays high continuously from PRIME to the last ADV. It is never dropped between passes, so the LFSR does not re-prime.
- RSTN asserted mid-run returns the block to IDLE immediately and deasserts every strobe asynchronously. The LFSR, which is reset by the same signal, restarts at 16'h8000.
- A fail on the last address pulses FAIL_VLD in the same cycle that precedes DONE.

## Configuration
- BIST_INV_PASS_EN defined: two passes (P=2). Pass 1 writes and compares ~PAT while continuing the LFSR sequence.
- BIST_INV_PASS_EN undefined: single pass (P=1). The pass bit and inversion logic are absent, and ADV on the last address goes straight to DONE.

## Structure
- Shared package bist_pkg holds:
  - the state enum (IDLE, PRIME, WR, RD, CMP, ADV, DONE);
  - the LFSR seed constant 16'h8000;
  - the LFSR first-step length (5) and step period (4) constants.
- One sub-module, bist_fail_log, contains the fail counter, saturation, overflow compare and FAIL_ADDR register.

## Test plan
- AW=2, fault-free memory model: writes to addresses 0..3 are 8000, 0001, 0002, 0004; no FAIL_VLD; DONE 18 cycles after START (macro off) or 34 cycles after START (macro on).
- Macro on, AW=2: pass-1 writes are FFF7, FFEF, FFDF, FFBF to addresses 0..3.
- Stuck-at-0 on bit 0 of address 1 -> FAIL_VLD with FAIL_ADDR=1 in the pass-0 ADV of slot 1; FAIL_CNT=1 (FAIL_CNT=2 with the macro on, from the pass-1 fail at 1).
- AW=3, all 8 addresses faulty, MAX_FAIL=4 -> OVERFLOW sets on the 5th FAIL_VLD; FAIL_CNT=8 at DONE; the next START clears both.
- START pulsed during BUSY -> no restart and unchanged DONE time. RSTN pulsed mid-run -> outputs at reset values; a new START yields 8000 again as the first write.
- Back-to-back runs: LFSR_EN low in DONE/IDLE; the second run's first write equals the LFSR's held word; the compare still passes.
